// File: rtl/i2s_stream_tx.sv
// Streaming stereo I2S / left-justified / right-justified transmitter with a sample-pair FIFO.
// All logic runs on MCLK. SCLK and LRCLK are generated data outputs and never act as clocks.
module i2s_stream_tx #(
  parameter int BIT_DEPTH  = 16,
  parameter int SLOT_BITS  = 16,
  parameter int CLK_DIV    = 35,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          MCLK,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic                          mono,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [BIT_DEPTH-1:0]          s_left,
  input  logic [BIT_DEPTH-1:0]          s_right,
  output logic                          SCLK,
  output logic                          LRCLK,
  output logic                          SD,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = $clog2(CLK_DIV);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int LW         = AW + 1;
  localparam int IW         = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;

  logic [2*BIT_DEPTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [LW-1:0]          r_level;
  logic [DW-1:0]          r_div;
  logic                   r_sclk;
  logic [BW-1:0]          r_b;
  logic                   r_lrclk;
  logic                   r_sd;
  logic                   r_under;
  logic                   r_en_d;
  logic [1:0]             r_mode;
  logic                   r_mono;
  logic [BIT_DEPTH-1:0]   r_left;
  logic [BIT_DEPTH-1:0]   r_right;

  logic                   w_ready;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_div_tc;
  logic                   w_fall;
  logic                   w_wrap;
  logic                   w_first;
  logic                   w_start;
  logic [BW-1:0]          w_b_next;
  logic [1:0]             w_mode_in;
  logic [BIT_DEPTH-1:0]   w_new_left;
  logic [BIT_DEPTH-1:0]   w_new_right;
  logic [BIT_DEPTH-1:0]   w_cur_left;
  logic [BIT_DEPTH-1:0]   w_cur_right;
  logic [1:0]             w_cur_mode;
  logic                   w_cur_mono;
  logic                   w_bit_new;
  logic                   w_bit_old;
  logic                   w_sd_next;
  logic                   w_lr_next;

  // Value of frame bit b for a given sample pair and framing; padding is always zero.
  function automatic logic frame_bit(input int b,
                                     input logic [BIT_DEPTH-1:0] l,
                                     input logic [BIT_DEPTH-1:0] r,
                                     input logic [1:0] md,
                                     input logic mn);
    int                   pos;
    logic [BIT_DEPTH-1:0] smp;
    logic [IW-1:0]        idx;
    logic                 bitv;
    bitv = 1'b0;
    idx  = '0;
    if (b >= SLOT_BITS) begin
      pos = b - SLOT_BITS;
      smp = mn ? l : r;
    end else begin
      pos = b;
      smp = l;
    end
    if (md == 2'd2) begin
      if (pos >= SLOT_BITS - BIT_DEPTH) begin
        idx  = IW'(SLOT_BITS - 1 - pos);
        bitv = smp[idx];
      end
    end else if (pos < BIT_DEPTH) begin
      idx  = IW'(BIT_DEPTH - 1 - pos);
      bitv = smp[idx];
    end
    return bitv;
  endfunction

  assign w_ready   = (r_level != LW'(FIFO_DEPTH));
  assign w_push    = s_valid && w_ready;
  assign w_div_tc  = (r_div == DW'(CLK_DIV - 1));
  assign w_fall    = w_div_tc && r_sclk;
  assign w_wrap    = (r_b == BW'(FRAME_BITS - 1));
  assign w_first   = enable && !r_en_d;
  assign w_start   = enable && (w_first || (w_fall && w_wrap));
  // The pop looks at the registered level, so a push in the same cycle cannot satisfy it.
  assign w_pop     = w_start && (r_level != '0);
  assign w_b_next  = w_start ? '0 : r_b + BW'(1);
  assign w_mode_in = (mode == 2'd3) ? 2'd0 : mode;

  assign w_new_left  = w_pop ? r_mem[r_rptr][2*BIT_DEPTH-1:BIT_DEPTH] : '0;
  assign w_new_right = w_pop ? r_mem[r_rptr][BIT_DEPTH-1:0]           : '0;

  // At a frame start the next bit comes from the freshly loaded pair and mode.
  assign w_cur_left  = w_start ? w_new_left  : r_left;
  assign w_cur_right = w_start ? w_new_right : r_right;
  assign w_cur_mode  = w_start ? w_mode_in   : r_mode;
  assign w_cur_mono  = w_start ? mono        : r_mono;

  assign w_bit_new = frame_bit(int'(w_b_next), w_cur_left, w_cur_right, w_cur_mode, w_cur_mono);
  // I2S delay: the outgoing bit is the one of the current b, taken from the old frame at a wrap.
  assign w_bit_old = w_first ? 1'b0 : frame_bit(int'(r_b), r_left, r_right, r_mode, r_mono);
  assign w_sd_next = (w_cur_mode == 2'd0) ? w_bit_old : w_bit_new;
  assign w_lr_next = (w_b_next >= BW'(SLOT_BITS)) ^ (w_cur_mode != 2'd0);

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_en_d  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_div   <= '0;
      r_sclk  <= 1'b0;
      r_b     <= '0;
      r_lrclk <= 1'b0;
      r_sd    <= 1'b0;
      r_under <= 1'b0;
      r_mode  <= 2'd0;
      r_mono  <= 1'b0;
    end else begin
      r_en_d <= enable;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);

      if (!enable) begin
        r_div   <= '0;
        r_sclk  <= 1'b0;
        r_b     <= '0;
        r_lrclk <= 1'b0;
        r_sd    <= 1'b0;
      end else if (w_first) begin
        r_div   <= '0;
        r_sclk  <= 1'b0;
        r_b     <= '0;
        r_lrclk <= w_lr_next;
        r_sd    <= w_sd_next;
      end else begin
        if (w_div_tc) begin
          r_div  <= '0;
          r_sclk <= ~r_sclk;
        end else begin
          r_div  <= r_div + DW'(1);
        end
        if (w_fall) begin
          r_b     <= w_b_next;
          r_lrclk <= w_lr_next;
          r_sd    <= w_sd_next;
        end
      end

      if (w_start) begin
        r_mode <= w_mode_in;
        r_mono <= mono;
      end

      // An underrun at the enable frame start wins over the enable-edge clear.
      if (w_start && (r_level == '0)) r_under <= 1'b1;
      else if (w_first)               r_under <= 1'b0;
    end
  end

  always_ff @(posedge MCLK) begin
    if (w_push && !reset) r_mem[r_wptr] <= {s_left, s_right};
    if (w_start) begin
      r_left  <= w_new_left;
      r_right <= w_new_right;
    end
  end

  assign s_ready    = w_ready;
  assign SCLK       = r_sclk;
  assign LRCLK      = r_lrclk;
  assign SD         = r_sd;
  assign underrun   = r_under;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Directed bench for i2s_stream_tx: default instance for stereo framings, a 24-in-32 instance for right-justified mono.
module tb_i2s_stream_tx;

  logic        MCLK;
  logic        reset;
  int          n_checks;
  int          n_fail;

  logic        en_a, mono_a, valid_a, ready_a, sclk_a, lr_a, sd_a, und_a;
  logic [1:0]  mode_a;
  logic [15:0] left_a, right_a;
  logic [3:0]  lvl_a;

  logic        en_b, mono_b, valid_b, ready_b, sclk_b, lr_b, sd_b, und_b;
  logic [1:0]  mode_b;
  logic [23:0] left_b, right_b;
  logic [2:0]  lvl_b;

  i2s_stream_tx dut_a (
    .MCLK(MCLK), .reset(reset), .enable(en_a), .mode(mode_a), .mono(mono_a),
    .s_valid(valid_a), .s_ready(ready_a), .s_left(left_a), .s_right(right_a),
    .SCLK(sclk_a), .LRCLK(lr_a), .SD(sd_a), .underrun(und_a), .fifo_level(lvl_a)
  );

  i2s_stream_tx #(.BIT_DEPTH(24), .SLOT_BITS(32), .CLK_DIV(4), .FIFO_DEPTH(4)) dut_b (
    .MCLK(MCLK), .reset(reset), .enable(en_b), .mode(mode_b), .mono(mono_b),
    .s_valid(valid_b), .s_ready(ready_b), .s_left(left_b), .s_right(right_b),
    .SCLK(sclk_b), .LRCLK(lr_b), .SD(sd_b), .underrun(und_b), .fifo_level(lvl_b)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge MCLK);
    reset = 1'b1;
    repeat (2) @(negedge MCLK);
    reset = 1'b0;
  endtask

  task automatic push_a(input logic [15:0] l, input logic [15:0] r);
    left_a  = l;
    right_a = r;
    valid_a = 1'b1;
    @(negedge MCLK);
    valid_a = 1'b0;
  endtask

  // Collects SD and LRCLK at n SCLK rising edges (MSB = first edge), bounded per edge.
  task automatic capture(input bit sel, input int n, output logic [63:0] sd_v,
                         output logic [63:0] lr_v, output int first_cnt, output bit ok);
    logic prev, cur;
    int   cyc;
    sd_v = '0; lr_v = '0; ok = 1'b1; first_cnt = 0; cyc = 0;
    prev = sel ? sclk_b : sclk_a;
    for (int k = 0; k < n; k++) begin
      bit got;
      got = 1'b0;
      for (int t = 0; t < 400 && !got; t++) begin
        @(negedge MCLK);
        cyc++;
        cur = sel ? sclk_b : sclk_a;
        if (!prev && cur) begin
          got  = 1'b1;
          sd_v = {sd_v[62:0], sel ? sd_b : sd_a};
          lr_v = {lr_v[62:0], sel ? lr_b : lr_a};
          if (k == 0) first_cnt = cyc;
        end
        prev = cur;
      end
      if (!got) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge MCLK);
    n_checks++; if (sclk_a !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk_a); end
    n_checks++; if (lr_a !== 1'b0) begin n_fail++; $display("FAIL reset_lrclk: got %b want 0", lr_a); end
    n_checks++; if (sd_a !== 1'b0) begin n_fail++; $display("FAIL reset_sd: got %b want 0", sd_a); end
    n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_a); end
    n_checks++; if (und_a !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", und_a); end
    n_checks++; if (lvl_a !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", lvl_a); end
    reset = 1'b0;
  endtask

  task automatic test_left_justified();
    logic [63:0] sd_v, lr_v;
    int   first, cnt;
    bit   ok, found;
    logic prev;
    do_reset();
    push_a(16'hA5C3, 16'h0F01);
    n_checks++; if (lvl_a !== 4'd1) begin n_fail++; $display("FAIL lj_level_push: got %0d want 1", lvl_a); end
    mode_a = 2'd1;
    en_a   = 1'b1;
    capture(1'b0, 32, sd_v, lr_v, first, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL lj_timeout: got no SCLK want 32 edges"); end
    n_checks++; if (first !== 36) begin n_fail++; $display("FAIL lj_first_rise: got %0d want 36", first); end
    n_checks++; if (sd_v[31:0] !== 32'hA5C30F01) begin n_fail++; $display("FAIL lj_sd: got %h want a5c30f01", sd_v[31:0]); end
    n_checks++; if (lr_v[31:0] !== 32'hFFFF0000) begin n_fail++; $display("FAIL lj_lrclk: got %h want ffff0000", lr_v[31:0]); end
    n_checks++; if (lvl_a !== 4'd0) begin n_fail++; $display("FAIL lj_level_pop: got %0d want 0", lvl_a); end
    found = 1'b0;
    prev  = lr_a;
    for (int t = 0; t < 3000 && !found; t++) begin
      @(negedge MCLK);
      if (!prev && lr_a) found = 1'b1;
      prev = lr_a;
    end
    cnt = 0;
    found = 1'b0;
    for (int t = 0; t < 3000 && !found; t++) begin
      @(negedge MCLK);
      cnt++;
      if (!prev && lr_a) found = 1'b1;
      prev = lr_a;
    end
    n_checks++; if (!found || cnt !== 2240) begin n_fail++; $display("FAIL lj_frame_period: got %0d want 2240", cnt); end
    en_a = 1'b0;
  endtask

  task automatic test_i2s_delay();
    logic [63:0] sd_v, lr_v;
    int first;
    bit ok;
    do_reset();
    push_a(16'hA5C3, 16'h0F01);
    mode_a = 2'd0;
    en_a   = 1'b1;
    @(negedge MCLK);
    n_checks++; if (sd_a !== 1'b0 || lr_a !== 1'b0) begin n_fail++; $display("FAIL i2s_b0: got sd=%b lr=%b want sd=0 lr=0", sd_a, lr_a); end
    capture(1'b0, 33, sd_v, lr_v, first, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL i2s_timeout: got no SCLK want 33 edges"); end
    n_checks++; if (sd_v[32:0] !== 33'h0A5C30F01) begin n_fail++; $display("FAIL i2s_sd: got %h want 0a5c30f01", sd_v[32:0]); end
    n_checks++; if (lr_v[32:0] !== 33'h00001FFFE) begin n_fail++; $display("FAIL i2s_lrclk: got %h want 1fffe", lr_v[32:0]); end
    n_checks++; if (sd_v[0] !== 1'b1 || lr_v[0] !== 1'b0) begin n_fail++; $display("FAIL i2s_r_lsb_next_frame: got sd=%b lr=%b want sd=1 lr=0", sd_v[0], lr_v[0]); end
    en_a = 1'b0;
  endtask

  task automatic test_underrun();
    logic [63:0] sd_v, lr_v;
    int first;
    bit ok;
    do_reset();
    mode_a = 2'd1;
    en_a   = 1'b1;
    @(negedge MCLK);
    n_checks++; if (und_a !== 1'b1) begin n_fail++; $display("FAIL ur_flag_set: got %b want 1", und_a); end
    capture(1'b0, 31, sd_v, lr_v, first, ok);
    n_checks++; if (!ok || sd_v[30:0] !== 31'd0) begin n_fail++; $display("FAIL ur_sd_zero: got %h want 0", sd_v[30:0]); end
    push_a(16'h8001, 16'h4002);
    n_checks++; if (lvl_a !== 4'd1) begin n_fail++; $display("FAIL ur_level: got %0d want 1", lvl_a); end
    capture(1'b0, 33, sd_v, lr_v, first, ok);
    n_checks++; if (!ok || sd_v[31:0] !== 32'h80014002) begin n_fail++; $display("FAIL ur_late_push_sd: got %h want 80014002", sd_v[31:0]); end
    n_checks++; if (und_a !== 1'b1) begin n_fail++; $display("FAIL ur_sticky: got %b want 1", und_a); end
    en_a = 1'b0;
    @(negedge MCLK);
    n_checks++; if (sclk_a !== 1'b0 || sd_a !== 1'b0 || lr_a !== 1'b0) begin n_fail++; $display("FAIL ur_disabled_idle: got sclk=%b sd=%b lr=%b want 000", sclk_a, sd_a, lr_a); end
    push_a(16'h1111, 16'h2222);
    n_checks++; if (und_a !== 1'b1) begin n_fail++; $display("FAIL ur_hold_while_off: got %b want 1", und_a); end
    en_a = 1'b1;
    @(negedge MCLK);
    n_checks++; if (und_a !== 1'b0 || lr_a !== 1'b1) begin n_fail++; $display("FAIL ur_clear_on_enable: got und=%b lr=%b want und=0 lr=1", und_a, lr_a); end
    en_a = 1'b0;
  endtask

  task automatic test_backpressure_and_reset();
    logic [63:0] sd_v, lr_v;
    logic [31:0] pair;
    int   first, idx;
    bit   ok, rdy;
    do_reset();
    mode_a  = 2'd1;
    idx     = 0;
    valid_a = 1'b1;
    left_a  = 16'h1000;
    right_a = 16'h2000;
    repeat (12) begin
      rdy = ready_a;
      @(negedge MCLK);
      if (rdy) begin
        idx++;
        left_a  = 16'h1000 + 16'(idx);
        right_a = 16'h2000 + 16'(idx);
      end
    end
    n_checks++; if (lvl_a !== 4'd8 || idx !== 8) begin n_fail++; $display("FAIL bp_level_full: got %0d (%0d pushes) want 8", lvl_a, idx); end
    n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", ready_a); end
    valid_a = 1'b0;
    en_a    = 1'b1;
    @(negedge MCLK);
    n_checks++; if (ready_a !== 1'b1 || lvl_a !== 4'd7) begin n_fail++; $display("FAIL bp_ready_after_pop: got rdy=%b lvl=%0d want rdy=1 lvl=7", ready_a, lvl_a); end
    for (int f = 0; f < 3; f++) begin
      capture(1'b0, 32, sd_v, lr_v, first, ok);
      pair = {16'h1000 + 16'(f), 16'h2000 + 16'(f)};
      n_checks++; if (!ok || sd_v[31:0] !== pair) begin n_fail++; $display("FAIL bp_order_%0d: got %h want %h", f, sd_v[31:0], pair); end
    end
    n_checks++; if (lvl_a !== 4'd5) begin n_fail++; $display("FAIL bp_level_drain: got %0d want 5", lvl_a); end
    capture(1'b0, 21, sd_v, lr_v, first, ok);
    pair = 32'h10032003;
    n_checks++; if (!ok || sd_v[20:0] !== pair[31:11]) begin n_fail++; $display("FAIL rst_pre_b20: got %h want %h", sd_v[20:0], pair[31:11]); end
    reset   = 1'b1;
    valid_a = 1'b1;
    left_a  = 16'hDEAD;
    right_a = 16'hBEEF;
    @(negedge MCLK);
    n_checks++; if (sclk_a !== 1'b0 || lr_a !== 1'b0 || sd_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got sclk=%b lr=%b sd=%b want 000", sclk_a, lr_a, sd_a); end
    n_checks++; if (lvl_a !== 4'd0 || ready_a !== 1'b1 || und_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fifo: got lvl=%0d rdy=%b und=%b want 0 1 0", lvl_a, ready_a, und_a); end
    reset   = 1'b0;
    valid_a = 1'b0;
    en_a    = 1'b0;
    @(negedge MCLK);
    push_a(16'hC3A5, 16'h5A0F);
    en_a = 1'b1;
    capture(1'b0, 32, sd_v, lr_v, first, ok);
    n_checks++; if (!ok || sd_v[31:0] !== 32'hC3A55A0F) begin n_fail++; $display("FAIL rst_restart_sd: got %h want c3a55a0f", sd_v[31:0]); end
    n_checks++; if (lr_v[31:0] !== 32'hFFFF0000) begin n_fail++; $display("FAIL rst_restart_lrclk: got %h want ffff0000", lr_v[31:0]); end
    en_a = 1'b0;
  endtask

  task automatic test_rj_mono();
    logic [63:0] sd_v, lr_v;
    int first;
    bit ok;
    do_reset();
    left_b  = 24'h800001;
    right_b = 24'h123456;
    valid_b = 1'b1;
    @(negedge MCLK);
    valid_b = 1'b0;
    n_checks++; if (lvl_b !== 3'd1) begin n_fail++; $display("FAIL rj_level: got %0d want 1", lvl_b); end
    mode_b = 2'd2;
    mono_b = 1'b1;
    en_b   = 1'b1;
    capture(1'b1, 64, sd_v, lr_v, first, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rj_timeout: got no SCLK want 64 edges"); end
    n_checks++; if (sd_v !== 64'h0080000100800001) begin n_fail++; $display("FAIL rj_mono_sd: got %h want 0080000100800001", sd_v); end
    n_checks++; if (lr_v !== 64'hFFFFFFFF00000000) begin n_fail++; $display("FAIL rj_lrclk: got %h want ffffffff00000000", lr_v); end
    en_b = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    en_a = 1'b0; mode_a = 2'd0; mono_a = 1'b0; valid_a = 1'b0; left_a = '0; right_a = '0;
    en_b = 1'b0; mode_b = 2'd0; mono_b = 1'b0; valid_b = 1'b0; left_b = '0; right_b = '0;
    test_reset();
    test_left_justified();
    test_i2s_delay();
    test_underrun();
    test_backpressure_and_reset();
    test_rj_mono();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
